cpu_bus_arb: RTL and testbench

CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

---
 rtl/cpu_bus_arb_pkg.sv | 28 ++
 rtl/cpu_bus_arb_if.sv | 28 ++
 rtl/cpu_bus_arb.sv | 168 ++++++++++++++++
 tb/tb_cpu_bus_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bexkat1Def (package)
//  Brief    : Shared CPU bus definitions: arbiter state encoding, grant codes
//             and Wishbone field widths.
//  Revision : 1.0 - initial release
// ============================================================================
package bexkat1Def;

   // Wishbone field widths shared by every bus endpoint in the core
   localparam int c_wb_adr_w = 32;
   localparam int c_wb_dat_w = 32;
   localparam int c_wb_sel_w = 4;

   // Grant encoding seen on the debug grant output
   localparam logic [1:0] c_grant_none = 2'd0;
   localparam logic [1:0] c_grant_ins  = 2'd1;
   localparam logic [1:0] c_grant_dat  = 2'd2;

   // Arbiter ownership states; encodings line up with the grant codes
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INS  = 2'd1,
      DAT  = 2'd2
   } arb_state_t;

endpackage : bexkat1Def
`default_nettype wire

// File: rtl/cpu_bus_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_wb
//  Brief    : Pipelined Wishbone bundle. The master drives cycle/strobe and
//             the request fields; the slave returns data, ack and stall.
//  Revision : 1.0 - initial release
// ============================================================================
interface if_wb;
   import bexkat1Def::*;

   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [c_wb_sel_w-1:0] sel;
   logic [c_wb_adr_w-1:0] adr;
   logic [c_wb_dat_w-1:0] dat_m;
   logic [c_wb_dat_w-1:0] dat_s;
   logic                  ack;
   logic                  stall;

   modport master (output cyc, stb, we, sel, adr, dat_m,
                   input  dat_s, ack, stall);

   modport slave  (input  cyc, stb, we, sel, adr, dat_m,
                   output dat_s, ack, stall);

endinterface : if_wb
`default_nettype wire

// File: rtl/cpu_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_arb
//  Brief    : Two-requester (instruction fetch / load-store) arbiter onto a
//             single pipelined Wishbone memory port. Non-preemptive tenures,
//             alternating priority on contention, outstanding-strobe limit.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_arb
   import bexkat1Def::*;
#(
   parameter int MAX_OUT = 8,
   parameter int CNT_W   = 4
)(
   input  logic       clk_i,
   input  logic       rst_i,
   if_wb.slave        ins_bus,
   if_wb.slave        dat_bus,
   if_wb.master       mem_bus,
   output logic [1:0] grant
);

   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   arb_state_t             r_state;
   arb_state_t             w_state_nxt;
   logic                   r_last_dat;
   logic                   w_last_dat_nxt;
   logic [CNT_W-1:0]       r_out_cnt;
   logic [CNT_W-1:0]       w_out_cnt_nxt;

   logic                   w_own_cyc;
   logic                   w_own_stb;
   logic                   w_own_we;
   logic [c_wb_sel_w-1:0]  w_own_sel;
   logic [c_wb_adr_w-1:0]  w_own_adr;
   logic [c_wb_dat_w-1:0]  w_own_dat;

   logic                   w_cnt_zero;
   logic                   w_full;
   logic                   w_mem_stb;
   logic                   w_accept;
   logic                   w_ack_ok;

   assign w_cnt_zero = (r_out_cnt == '0);
   assign w_full     = (r_out_cnt == c_cnt_max);
   // Strobes are withheld once the outstanding window is full
   assign w_mem_stb  = w_own_cyc & w_own_stb & ~w_full;
   assign w_accept   = w_mem_stb & ~mem_bus.stall;
   // An ack with nothing outstanding is spurious and is swallowed
   assign w_ack_ok   = mem_bus.ack & ~w_cnt_zero;

   // Select the request fields of whichever requester owns the bus
   always_comb begin
      w_own_cyc = 1'b0;
      w_own_stb = 1'b0;
      w_own_we  = 1'b0;
      w_own_sel = '0;
      w_own_adr = '0;
      w_own_dat = '0;
      case (r_state)
         INS: begin
            w_own_cyc = ins_bus.cyc;
            w_own_stb = ins_bus.stb;
            w_own_we  = ins_bus.we;
            w_own_sel = ins_bus.sel;
            w_own_adr = ins_bus.adr;
            w_own_dat = ins_bus.dat_m;
         end
         DAT: begin
            w_own_cyc = dat_bus.cyc;
            w_own_stb = dat_bus.stb;
            w_own_we  = dat_bus.we;
            w_own_sel = dat_bus.sel;
            w_own_adr = dat_bus.adr;
            w_own_dat = dat_bus.dat_m;
         end
         default: ;
      endcase
   end

   // Ownership decision: dat first unless it was served last, no preemption
   always_comb begin
      w_state_nxt    = r_state;
      w_last_dat_nxt = r_last_dat;
      case (r_state)
         IDLE: begin
            if (dat_bus.cyc && (!ins_bus.cyc || !r_last_dat)) begin
               w_state_nxt    = DAT;
               w_last_dat_nxt = 1'b1;
            end else if (ins_bus.cyc) begin
               w_state_nxt    = INS;
               w_last_dat_nxt = 1'b0;
            end
         end
         INS, DAT: begin
            // Tenure ends only once the owner is done and nothing is in flight
            if (!w_own_cyc && w_cnt_zero) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outstanding count: +1 per accepted strobe, -1 per valid ack
   always_comb begin
      w_out_cnt_nxt = r_out_cnt;
      if (w_accept && !w_ack_ok) begin
         w_out_cnt_nxt = r_out_cnt + c_cnt_one;
      end else if (!w_accept && w_ack_ok) begin
         w_out_cnt_nxt = r_out_cnt - c_cnt_one;
      end
   end

   // Bus steering; reset forces the quiet idle view regardless of state
   always_comb begin
      grant         = c_grant_none;
      mem_bus.cyc   = 1'b0;
      mem_bus.stb   = 1'b0;
      mem_bus.we    = 1'b0;
      mem_bus.sel   = '0;
      mem_bus.adr   = '0;
      mem_bus.dat_m = '0;
      ins_bus.stall = 1'b1;
      ins_bus.ack   = 1'b0;
      ins_bus.dat_s = '0;
      dat_bus.stall = 1'b1;
      dat_bus.ack   = 1'b0;
      dat_bus.dat_s = '0;
      if (!rst_i && (r_state == INS || r_state == DAT)) begin
         // cyc stays up after the owner drops it until all acks are back
         mem_bus.cyc   = w_own_cyc | ~w_cnt_zero;
         mem_bus.stb   = w_mem_stb;
         mem_bus.we    = w_own_we;
         mem_bus.sel   = w_own_sel;
         mem_bus.adr   = w_own_adr;
         mem_bus.dat_m = w_own_dat;
         if (r_state == INS) begin
            grant         = c_grant_ins;
            ins_bus.stall = mem_bus.stall | w_full;
            ins_bus.ack   = w_ack_ok;
            ins_bus.dat_s = mem_bus.dat_s;
         end else begin
            grant         = c_grant_dat;
            dat_bus.stall = mem_bus.stall | w_full;
            dat_bus.ack   = w_ack_ok;
            dat_bus.dat_s = mem_bus.dat_s;
         end
      end
   end

   // State, fairness marker and outstanding counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_last_dat <= 1'b0;
         r_out_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_last_dat <= w_last_dat_nxt;
         r_out_cnt  <= w_out_cnt_nxt;
      end
   end

endmodule : cpu_bus_arb
`default_nettype wire

// File: tb/tb_cpu_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_bus_arb
//  Brief    : Self-checking bench for cpu_bus_arb: directed scenarios with
//             literal expectations plus a per-cycle behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_arb;

   localparam int MAX_OUT = 8;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [1:0] grant;

   int checks   = 0;
   int failures = 0;

   if_wb ins_if ();
   if_wb dat_if ();
   if_wb mem_if ();

   cpu_bus_arb #(.MAX_OUT(MAX_OUT), .CNT_W(4)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .ins_bus (ins_if),
      .dat_bus (dat_if),
      .mem_bus (mem_if),
      .grant   (grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ins_set(input logic c, input logic s, input logic [31:0] a);
      ins_if.cyc   = c;
      ins_if.stb   = s;
      ins_if.we    = 1'b0;
      ins_if.sel   = 4'hF;
      ins_if.adr   = a;
      ins_if.dat_m = a ^ 32'h1111_0000;
   endtask

   task automatic dat_set(input logic c, input logic s, input logic [31:0] a);
      dat_if.cyc   = c;
      dat_if.stb   = s;
      dat_if.we    = 1'b1;
      dat_if.sel   = 4'h3;
      dat_if.adr   = a;
      dat_if.dat_m = a ^ 32'h2222_0000;
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: owner id (0/1/2), in-flight count, who went last.
   // ---------------------------------------------------------------------
   int          m_owner    = 0;
   int          m_cnt      = 0;
   bit          m_last_dat = 1'b0;
   bit          m_valid    = 1'b0;
   int          e_grant;
   bit          e_cyc, e_stb, e_we;
   bit          e_ins_stall, e_ins_ack, e_dat_stall, e_dat_ack;
   bit          oc, os, owe, full, own_stall, own_ack, acc, ak, leave;
   logic [31:0] oadr, odat_s;

   always @(negedge clk) begin
      if (rst_i) begin
         e_grant = 0; e_cyc = 0; e_stb = 0; e_we = 0;
         e_ins_stall = 1; e_ins_ack = 0; e_dat_stall = 1; e_dat_ack = 0;
         oc = 0; os = 0; owe = 0; oadr = '0;
      end else begin
         if (m_owner == 1) begin
            oc = ins_if.cyc; os = ins_if.stb; owe = ins_if.we; oadr = ins_if.adr;
         end else if (m_owner == 2) begin
            oc = dat_if.cyc; os = dat_if.stb; owe = dat_if.we; oadr = dat_if.adr;
         end else begin
            oc = 0; os = 0; owe = 0; oadr = '0;
         end
         full      = (m_cnt >= MAX_OUT);
         own_stall = mem_if.stall || full;
         own_ack   = mem_if.ack && (m_cnt > 0);
         e_grant   = m_owner;
         e_cyc     = (m_owner != 0) && (oc || (m_cnt > 0));
         e_stb     = (m_owner != 0) && oc && os && !full;
         e_we      = (m_owner != 0) && owe;
         e_ins_stall = (m_owner == 1) ? own_stall : 1'b1;
         e_ins_ack   = (m_owner == 1) ? own_ack   : 1'b0;
         e_dat_stall = (m_owner == 2) ? own_stall : 1'b1;
         e_dat_ack   = (m_owner == 2) ? own_ack   : 1'b0;
      end

      if (m_valid) begin
         chk("model grant",     32'(grant),        32'(e_grant));
         chk("model mem_cyc",   32'(mem_if.cyc),   32'(e_cyc));
         chk("model mem_stb",   32'(mem_if.stb),   32'(e_stb));
         chk("model mem_we",    32'(mem_if.we),    32'(e_we));
         chk("model ins_stall", 32'(ins_if.stall), 32'(e_ins_stall));
         chk("model ins_ack",   32'(ins_if.ack),   32'(e_ins_ack));
         chk("model dat_stall", 32'(dat_if.stall), 32'(e_dat_stall));
         chk("model dat_ack",   32'(dat_if.ack),   32'(e_dat_ack));
         chk("model count",     32'(dut.r_out_cnt), 32'(m_cnt));
         if (!rst_i && m_owner != 0) begin
            odat_s = (m_owner == 1) ? ins_if.dat_s : dat_if.dat_s;
            chk("model mem_adr",   mem_if.adr, oadr);
            chk("model own_dat_s", odat_s,     mem_if.dat_s);
         end
      end

      // Advance the model with the inputs the next rising edge will see
      if (rst_i) begin
         m_owner = 0; m_cnt = 0; m_last_dat = 1'b0; m_valid = 1'b1;
      end else if (m_owner == 0) begin
         if (dat_if.cyc && ins_if.cyc) m_owner = m_last_dat ? 1 : 2;
         else if (dat_if.cyc)          m_owner = 2;
         else if (ins_if.cyc)          m_owner = 1;
      end else begin
         acc   = e_stb && !mem_if.stall;
         ak    = own_ack;
         leave = !oc && (m_cnt == 0);
         m_cnt = m_cnt + int'(acc) - int'(ak);
         if (leave) begin
            m_last_dat = (m_owner == 2);
            m_owner    = 0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed scenarios with hand-computed expectations
   // ---------------------------------------------------------------------
   int accepted;

   initial begin
      rst_i = 1'b1;
      ins_set(0, 0, 32'h0);
      dat_set(0, 0, 32'h0);
      mem_if.ack   = 1'b0;
      mem_if.stall = 1'b0;
      mem_if.dat_s = 32'h0;

      // Reset state
      step();
      chk("rst grant",     32'(grant),         32'd0);
      chk("rst mem_cyc",   32'(mem_if.cyc),    32'd0);
      chk("rst mem_stb",   32'(mem_if.stb),    32'd0);
      chk("rst ins_stall", 32'(ins_if.stall),  32'd1);
      chk("rst dat_stall", 32'(dat_if.stall),  32'd1);
      chk("rst count",     32'(dut.r_out_cnt), 32'd0);
      step(); rst_i = 1'b0; #1;
      chk("idle grant", 32'(grant), 32'd0);

      // Single instruction fetch at 0x100
      step(); ins_set(1, 1, 32'h100); #1;
      chk("fetch same-cycle grant", 32'(grant),      32'd0);
      chk("fetch same-cycle cyc",   32'(mem_if.cyc), 32'd0);
      step();
      chk("fetch grant",     32'(grant),        32'd1);
      chk("fetch mem_cyc",   32'(mem_if.cyc),   32'd1);
      chk("fetch mem_adr",   mem_if.adr,        32'h100);
      chk("fetch dat_stall", 32'(dat_if.stall), 32'd1);
      step(); ins_set(1, 0, 32'h100); mem_if.ack = 1'b1; mem_if.dat_s = 32'hCAFE_0001; #1;
      chk("fetch ins_ack",   32'(ins_if.ack),   32'd1);
      chk("fetch ins_dat_s", ins_if.dat_s,      32'hCAFE_0001);
      chk("fetch dat_ack",   32'(dat_if.ack),   32'd0);
      step(); mem_if.ack = 1'b0; ins_set(0, 0, 32'h0); #1;
      chk("fetch count done", 32'(dut.r_out_cnt), 32'd0);
      chk("fetch still owned", 32'(grant),        32'd1);
      step();
      chk("fetch released", 32'(grant), 32'd0);

      // Simultaneous requests straight after reset: dat wins, then ins
      rst_i = 1'b1;
      step(); rst_i = 1'b0; ins_set(1, 0, 32'h200); dat_set(1, 0, 32'h300); #1;
      chk("both idle", 32'(grant), 32'd0);
      step();
      chk("both dat first", 32'(grant), 32'd2);
      step(); dat_set(0, 0, 32'h0); #1;
      chk("both dat held", 32'(grant), 32'd2);
      step();
      chk("both idle gap", 32'(grant), 32'd0);
      step();
      chk("both ins next", 32'(grant),  32'd1);
      chk("both ins adr",  mem_if.adr,  32'h200);
      step(); ins_set(0, 0, 32'h0);
      step();
      chk("both released", 32'(grant), 32'd0);

      // Outstanding limit: slave holds acks
      step(); ins_set(1, 1, 32'h400); #1;
      step();
      chk("limit grant", 32'(grant), 32'd1);
      accepted = 0;
      for (int i = 0; i < 9; i++) begin
         if (!ins_if.stall) accepted++;
         step();
      end
      chk("limit accepted",  32'(accepted),      32'd8);
      chk("limit stall 9th", 32'(ins_if.stall),  32'd1);
      chk("limit mem_stb",   32'(mem_if.stb),    32'd0);
      chk("limit count",     32'(dut.r_out_cnt), 32'd8);
      mem_if.ack = 1'b1; #1;
      chk("limit ack fwd", 32'(ins_if.ack), 32'd1);
      step(); mem_if.ack = 1'b0; #1;
      chk("limit 9th accepted", 32'(ins_if.stall), 32'd0);
      step();
      chk("limit 10th stalls", 32'(ins_if.stall), 32'd1);
      ins_set(1, 0, 32'h400); mem_if.ack = 1'b1;
      for (int i = 0; i < 8; i++) step();
      mem_if.ack = 1'b0; ins_set(0, 0, 32'h0); #1;
      chk("limit drained", 32'(dut.r_out_cnt), 32'd0);
      step();
      chk("limit released", 32'(grant), 32'd0);

      // Owner drops cyc with 3 in flight while dat waits
      step(); ins_set(1, 1, 32'h500); #1;
      step(); dat_set(1, 0, 32'h600); #1;
      chk("drop owner ins", 32'(grant), 32'd1);
      step();
      step();
      step(); ins_set(0, 0, 32'h0); mem_if.ack = 1'b1; #1;
      chk("drop count 3",  32'(dut.r_out_cnt), 32'd3);
      chk("drop cyc held", 32'(mem_if.cyc),    32'd1);
      chk("drop ins_ack",  32'(ins_if.ack),    32'd1);
      step();
      chk("drop grant held", 32'(grant), 32'd1);
      step();
      step(); mem_if.ack = 1'b0; #1;
      chk("drop count 0",   32'(dut.r_out_cnt), 32'd0);
      chk("drop grant ins", 32'(grant),         32'd1);
      step();
      chk("drop idle gap", 32'(grant), 32'd0);
      step();
      chk("drop dat granted", 32'(grant), 32'd2);
      dat_set(0, 0, 32'h0);
      step();
      chk("drop released", 32'(grant), 32'd0);

      // Spurious ack while idle
      mem_if.ack = 1'b1; #1;
      chk("spurious ins_ack", 32'(ins_if.ack), 32'd0);
      chk("spurious dat_ack", 32'(dat_if.ack), 32'd0);
      step(); mem_if.ack = 1'b0; #1;
      chk("spurious count", 32'(dut.r_out_cnt), 32'd0);

      // Reset with 5 outstanding
      dat_set(1, 1, 32'h700);
      step();
      for (int i = 0; i < 5; i++) step();
      chk("rst5 count before", 32'(dut.r_out_cnt), 32'd5);
      dat_set(1, 0, 32'h700); rst_i = 1'b1; #1;
      chk("rst5 grant in rst",   32'(grant),        32'd0);
      chk("rst5 mem_cyc in rst", 32'(mem_if.cyc),   32'd0);
      chk("rst5 dat_stall",      32'(dat_if.stall), 32'd1);
      step(); rst_i = 1'b0; dat_set(0, 0, 32'h0); mem_if.ack = 1'b1; #1;
      chk("rst5 grant after", 32'(grant),         32'd0);
      chk("rst5 count after", 32'(dut.r_out_cnt), 32'd0);
      chk("rst5 late ack",    32'(dat_if.ack),    32'd0);
      step(); mem_if.ack = 1'b0; #1;
      chk("rst5 count stays", 32'(dut.r_out_cnt), 32'd0);
      dat_set(1, 1, 32'h800);
      step();
      chk("rst5 dat granted", 32'(grant), 32'd2);
      chk("rst5 dat adr",     mem_if.adr, 32'h800);
      dat_set(1, 0, 32'h800);
      step(); mem_if.ack = 1'b1; dat_set(0, 0, 32'h0);
      step(); mem_if.ack = 1'b0;
      step();
      chk("rst5 released", 32'(grant), 32'd0);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cpu_bus_arb
`default_nettype wire
